// File: rtl/seq_div_pkg.sv
// Shared definitions for the seq_div restoring divider: default widths and FSM state encoding.
package seq_div_pkg;

    localparam int DW_DEF = 10;
    localparam int VW_DEF = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        ROUND = ST_ROUND,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int VW = 5
) (
    input  logic [VW:0]   partial,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   partial_next,
    output logic          q_bit
);

    logic [VW+1:0] shifted;
    logic [VW:0]   diff;

    always_comb begin
        shifted      = {partial, bit_in};
        q_bit        = (shifted >= {2'b00, divisor});
        diff         = shifted[VW:0] - {1'b0, divisor};
        partial_next = q_bit ? diff : shifted[VW:0];
    end

endmodule

// File: rtl/seq_div.sv
// Iterative restoring divider, one quotient bit per clock with start/busy/done handshake.
// Define SEQ_DIV_ROUND_EN to add a round-to-nearest cycle (saturating) after the iterations.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    state_t        state;
    logic [DW-1:0] dividend_sr;
    logic [VW-1:0] divisor_r;
    logic [VW:0]   partial;
    logic [VW:0]   partial_next;
    logic          q_bit;
    logic [CW-1:0] count;
    logic [DW-1:0] sr_next;
    logic          last_iter;

    div_step #(.VW(VW)) u_step (
        .partial      (partial),
        .bit_in       (dividend_sr[DW-1]),
        .divisor      (divisor_r),
        .partial_next (partial_next),
        .q_bit        (q_bit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign sr_next   = {dividend_sr[DW-2:0], q_bit};
    assign last_iter = (count == CW'(1));

`ifdef SEQ_DIV_ROUND_EN
    logic round_up;
    assign round_up = ({partial[VW-1:0], 1'b0} >= {1'b0, divisor_r});
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dividend_sr <= '0;
            divisor_r   <= '0;
            partial     <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            dividend_sr <= dividend;
                            divisor_r   <= divisor;
                            partial     <= '0;
                            count       <= CW'(DW);
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    dividend_sr <= sr_next;
                    partial     <= partial_next;
                    count       <= count - CW'(1);
                    if (last_iter) begin
`ifdef SEQ_DIV_ROUND_EN
                        state <= ROUND;
`else
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= sr_next;
                        remainder <= partial_next[VW-1:0];
`endif
                    end
                end
`ifdef SEQ_DIV_ROUND_EN
                ROUND: begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    remainder <= partial[VW-1:0];
                    // Saturate instead of wrapping an all-ones quotient to zero.
                    if (round_up && !(&dividend_sr))
                        quotient <= dividend_sr + DW'(1);
                    else
                        quotient <= dividend_sr;
                end
`endif
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: directed operands, handshake corner cases, async reset, random operands.
module tb_seq_div;

    localparam int DW = 10;
    localparam int VW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int total = 0;
    int bad   = 0;
    int cur_a = 0;
    int cur_b = 0;

    seq_div #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic int exp_q(input int a, input int b);
        int q;
        if (b == 0) return (1 << DW) - 1;
        q = a / b;
`ifdef SEQ_DIV_ROUND_EN
        if (2 * (a % b) >= b && q < (1 << DW) - 1) q = q + 1;
`endif
        return q;
    endfunction

    function automatic int exp_r(input int a, input int b);
        return (b == 0) ? 0 : a % b;
    endfunction

    function automatic int exp_lat(input int b);
        if (b == 0) return 1;
`ifdef SEQ_DIV_ROUND_EN
        return DW + 2;
`else
        return DW + 1;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s (op %0d/%0d): got %0d expected %0d", tag, cur_a, cur_b, obs, expv);
        end
    endtask

    // Leaves the caller #1 after the edge that sampled start, i.e. in cycle 1.
    task automatic start_op(input int a, input int b);
        @(negedge clk);
        cur_a    = a;
        cur_b    = b;
        dividend = DW'(a);
        divisor  = VW'(b);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output int bc);
        lat = lat0;
        bc  = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input int a, input int b);
        chk("quotient", 32'(quotient), 32'(exp_q(a, b)));
        chk("remainder", 32'(remainder), 32'(exp_r(a, b)));
        chk("div_by_zero", 32'(div_by_zero), 32'(b == 0));
        chk("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic do_op(input int a, input int b);
        int lat, bc;
        start_op(a, b);
        wait_done(1, lat, bc);
        chk("latency", 32'(lat), 32'(exp_lat(b)));
        chk("busy_cycles", 32'(bc), 32'(exp_lat(b) - 1));
        check_result(a, b);
        @(posedge clk);
        #1;
        chk("done_pulse_width", 32'(done), 32'd0);
    endtask

    int dir_a[12] = '{651, 208, 72, 225, 100, 103, 1023, 500, 10, 0, 4, 1023};
    int dir_b[12] = '{21, 8, 12, 15, 7, 7, 1, 0, 3, 5, 31, 31};

    initial begin
        int lat, bc, ra, rb;

        #1 rst = 1'b1;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quotient", 32'(quotient), 32'd0);
        chk("reset_remainder", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) do_op(dir_a[i], dir_b[i]);

        // start pulsed during busy must be ignored
        start_op(651, 21);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        dividend = DW'(100);
        divisor  = VW'(7);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5, lat, bc);
        chk("ignored_start_latency", 32'(lat), 32'(exp_lat(21)));
        check_result(651, 21);
        @(posedge clk);
        #1;
        chk("ignored_start_single_done", 32'(done), 32'd0);
        chk("ignored_start_idle_busy", 32'(busy), 32'd0);

        // start held in the DONE cycle is accepted back-to-back
        start_op(208, 8);
        wait_done(1, lat, bc);
        check_result(208, 8);
        cur_a    = 225;
        cur_b    = 15;
        dividend = DW'(225);
        divisor  = VW'(15);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy_next_cycle", 32'(busy), 32'd1);
        chk("b2b_done_dropped", 32'(done), 32'd0);
        wait_done(1, lat, bc);
        chk("b2b_latency", 32'(lat), 32'(exp_lat(15)));
        check_result(225, 15);

        // divide by zero then a normal op clears the flag
        do_op(500, 0);
        do_op(10, 3);

        // asynchronous reset mid-operation
        do_op(100, 7);
        start_op(651, 21);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(72, 12);

        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, (1 << DW) - 1));
            rb = int'($urandom_range(0, (1 << VW) - 1));
            do_op(ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
